// File: rtl/wavelet_quantizer_if.sv
// Quantized-coefficient stream between wavelet_quantizer and the entropy coder.
// The master drives data/valid/last and the slave drives ready.
// A beat transfers on a cycle where q_valid && q_ready.
interface wavelet_quantizer_if;
    logic [7:0] q_data;
    logic       q_valid;
    logic       q_ready;
    logic       q_last;

    modport master (
        output q_data,
        output q_valid,
        output q_last,
        input  q_ready
    );

    modport slave (
        input  q_data,
        input  q_valid,
        input  q_last,
        output q_ready
    );
endinterface

// File: rtl/wavelet_quantizer.sv
// wavelet_quantizer: reads the 4096 coefficients of a 64x64 wavelet tile in raster order,
// quantizes each one with a per-subband right shift (truncation toward zero), saturates the
// result to +/-127 and streams it out through a 4-entry FIFO.
// Optional build macro QUANT_DEADZONE_EN: in the HL, LH and HH subbands a quantized
// magnitude of 1 is forced to 0. LL is never affected.
module wavelet_quantizer #(
    parameter int unsigned SHIFT_LL = 0,
    parameter int unsigned SHIFT_HL = 2,
    parameter int unsigned SHIFT_LH = 2,
    parameter int unsigned SHIFT_HH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [15:0]                ram_qout_i,
    output logic [11:0]                ram_address_o,
    wavelet_quantizer_if.master        q_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [11:0] LastAddr  = 12'hFFF;
    localparam int unsigned FifoDepth = 4;

    state_e      state_q;
    logic [11:0] addr_q;
    logic [11:0] raddr_q;     // address of the word currently arriving on ram_qout_i
    logic        inflight_q;  // a read was issued last cycle, its data arrives now
    logic        busy_q;
    logic        done_q;

    logic [8:0]  fifo_q [FifoDepth];  // {last, data}
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;

    logic        issue;
    logic        push;
    logic        pop;

    logic [1:0]  sb;
    logic [4:0]  sh_amt;
    logic        coef_neg;
    logic [16:0] mag;
    logic [16:0] shifted;
    logic [6:0]  mag_sat;
    logic [7:0]  mag_ext;
    logic [7:0]  q_val;
    logic        last_in;

    // Read credit: FIFO occupancy plus the read in flight never exceeds the FIFO depth,
    // so every returned word is guaranteed a slot.
    always_comb begin
        issue = 1'b0;
        if (state_q == StRun) begin
            issue = ({1'b0, cnt_q} + {3'b000, inflight_q}) < 4'(FifoDepth);
        end
    end

    assign push = inflight_q;
    assign pop  = (cnt_q != 3'd0) && q_o.q_ready;

    // FIFO occupancy next state; push and pop together leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Quantize the returning coefficient using the subband of its pipelined address.
    always_comb begin
        sb       = {raddr_q[11], raddr_q[5]};
        sh_amt   = 5'(SHIFT_LL);
        unique case (sb)
            2'b00:   sh_amt = 5'(SHIFT_LL);
            2'b01:   sh_amt = 5'(SHIFT_HL);
            2'b10:   sh_amt = 5'(SHIFT_LH);
            default: sh_amt = 5'(SHIFT_HH);
        endcase
        coef_neg = ram_qout_i[15];
        // 17-bit magnitude so that -32768 maps to +32768 without overflow.
        if (coef_neg) begin
            mag = 17'd0 - {1'b1, ram_qout_i};
        end else begin
            mag = {1'b0, ram_qout_i};
        end
        shifted = mag >> sh_amt;
        if (shifted > 17'd127) begin
            mag_sat = 7'd127;
        end else begin
            mag_sat = shifted[6:0];
        end
`ifdef QUANT_DEADZONE_EN
        if ((sb != 2'b00) && (mag_sat == 7'd1)) begin
            mag_sat = 7'd0;
        end
`else
`endif
        mag_ext  = {1'b0, mag_sat};
        if (coef_neg) begin
            q_val = 8'd0 - mag_ext;
        end else begin
            q_val = mag_ext;
        end
        last_in = (raddr_q == LastAddr);
    end

    // Control FSM with read address generation and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= 12'd0;
            raddr_q    <= 12'd0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                raddr_q <= addr_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        addr_q  <= 12'd0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (addr_q == LastAddr) begin
                            state_q <= StDrain;
                        end else begin
                            addr_q <= addr_q + 12'd1;
                        end
                    end
                end
                StDrain: begin
                    // No reads are issued here, so an empty next-count means the last beat
                    // has just been accepted and nothing is left in flight.
                    if (cnt_d == 3'd0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO storage and pointers; storage is cleared so q_data resets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_q[i] <= 9'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {last_in, q_val};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign ram_address_o = addr_q;
    assign q_o.q_data    = fifo_q[rd_ptr_q][7:0];
    assign q_o.q_last    = fifo_q[rd_ptr_q][8];
    assign q_o.q_valid   = (cnt_q != 3'd0);
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    // The credit rule must keep the FIFO from overflowing.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (cnt_q == 3'(FifoDepth))));

    // The completion pulse only happens once the stream is fully drained.
    a_done_idle_stream : assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q && (cnt_q != 3'd0)));

endmodule

// File: tb/tb_wavelet_quantizer.sv
// Bench for wavelet_quantizer: synchronous-read RAM model, quantizer reference model,
// one negedge compare process, and directed tiles (ramp, special values with random
// backpressure, mid-tile reset, back-to-back tiles).
module tb_wavelet_quantizer;

    localparam int ShLl = 0;
    localparam int ShHl = 2;
    localparam int ShLh = 2;
    localparam int ShHh = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ram_qout;
    logic [11:0] ram_address;
    logic        busy;
    logic        done;

    wavelet_quantizer_if qif ();

    wavelet_quantizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .ram_qout_i   (ram_qout),
        .ram_address_o(ram_address),
        .q_o          (qif),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [4096];

    always @(posedge clk) ram_qout <= mem[ram_address];

    bit ready_rand = 1'b0;

    always @(posedge clk) begin
        #1;
        qif.q_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference quantizer: plain integer arithmetic from the subband rules.
    function automatic logic signed [7:0] model_q(input logic [15:0] raw, input int addr);
        int  c;
        int  m;
        int  sh;
        bit  ll;
        c  = $signed(raw);
        m  = (c < 0) ? -c : c;
        ll = (addr[11] == 1'b0) && (addr[5] == 1'b0);
        if (ll)                 sh = ShLl;
        else if (addr[11] == 0) sh = ShHl;
        else if (addr[5] == 0)  sh = ShLh;
        else                    sh = ShHh;
        m = m >> sh;
        if (m > 127) m = 127;
`ifdef QUANT_DEADZONE_EN
        if (!ll && m == 1) m = 0;
`else
`endif
        return 8'((c < 0) ? -m : m);
    endfunction

    // Monitor state
    bit          in_tile = 1'b0;
    bit          hold = 1'b0;
    bit          stall_prev = 1'b0;
    int          start_cyc = 0;
    int          beat = 0;
    int          last_acc_cyc = 0;
    int          dones = 0;
    int          lasts = 0;
    int          tiles = 0;
    logic [7:0]  prev_data;
    logic [7:0]  got [4096];

    // Single compare process: model of busy/done/stream, checked every cycle.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        if (!rst_n) begin
            in_tile    = 1'b0;
            hold       = 1'b0;
            beat       = 0;
            stall_prev = 1'b0;
        end else if (start && !in_tile) begin
            check("busy_at_start", busy, 0);
            in_tile    = 1'b1;
            start_cyc  = cyc;
            beat       = 0;
            stall_prev = 1'b0;
            tiles++;
        end else begin
            exp_busy = in_tile && (cyc > start_cyc) && (beat < 4096);
            exp_done = in_tile && (beat == 4096);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (in_tile && cyc == start_cyc + 1) check("first_addr", ram_address, 0);
            if (busy) check("outstanding_le4", (int'(ram_address) - beat) <= 4, 1);
            if (!in_tile || exp_done) check("no_valid_idle", qif.q_valid, 0);
            if (hold && (!in_tile || exp_done)) check("addr_hold", ram_address, 4095);
            if (qif.q_valid && in_tile && beat < 4096) begin
                if (beat == 0 && !stall_prev) check("first_valid_cycle", cyc, start_cyc + 3);
                check("q_data", $signed(qif.q_data), model_q(mem[beat], beat));
                check("q_last", qif.q_last, beat == 4095);
                if (stall_prev) check("stall_stable", qif.q_data, prev_data);
                prev_data = qif.q_data;
                if (qif.q_ready) begin
                    got[beat] = qif.q_data;
                    if (qif.q_last) lasts++;
                    if (beat == 4095) begin
                        last_acc_cyc = cyc;
                        if (!ready_rand) check("last_beat_cycle", cyc, start_cyc + 4098);
                    end
                    beat++;
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                end
            end
            if (exp_done) begin
                check("done_after_last", cyc, last_acc_cyc + 1);
                in_tile = 1'b0;
                hold    = 1'b1;
                dones++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int n;
        d0 = dones;
        n  = 0;
        while (dones == d0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("tile_completed", dones != d0, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_q_valid", qif.q_valid, 0);
        check("rst_q_data", qif.q_data, 0);
        check("rst_q_last", qif.q_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_address, 0);
    endtask

    initial begin
        int d0;
        int n;
        int dz_small;
`ifdef QUANT_DEADZONE_EN
        dz_small = 0;
`else
        dz_small = -1;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Tile A: ramp, full throughput
        pulse_start();
        wait_done(6000);
        check("lit_addr5", $signed(got[5]), 5);
        check("lit_addr40", $signed(got[40]), 10);
        check("lit_addr2048", $signed(got[2048]), 127);
        check("lit_addr4095", $signed(got[4095]), 127);

        // Tile B: random data with special values, 30% ready, ignored start in RUN
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[0]    = 16'h8000;  // LL -32768
        mem[2]    = 16'h7FFF;  // LL +32767
        mem[2049] = 16'hFFF9;  // LH -7
        mem[2081] = 16'hFFF3;  // HH -13
        mem[40]   = 16'hFFFE;  // HL -2 -> 0 (toward zero)
        ready_rand = 1'b1;
        d0 = dones;
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        wait_done(40000);
        repeat (20) @(posedge clk);
        check("single_done", dones, d0 + 1);
        check("lit_ll_min", $signed(got[0]), -127);
        check("lit_ll_max", $signed(got[2]), 127);
        check("lit_lh_m7", $signed(got[2049]), dz_small);
        check("lit_hh_m13", $signed(got[2081]), dz_small);
        check("lit_hl_m2", $signed(got[40]), 0);

        // Tile C: reset at beat 1000
        ready_rand = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
        d0 = dones;
        pulse_start();
        n = 0;
        while (beat < 1000 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("reached_beat_1000", beat >= 1000, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("no_done_on_reset", dones, d0);

        // Restart after reset, then a back-to-back tile started the cycle after done
        pulse_start();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 6000);
        check("done_seen", done, 1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(6000);
        repeat (5) @(posedge clk);
        check("tiles_started", tiles, 5);
        check("last_per_tile", lasts, dones);
        check("total_dones", dones, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
